mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage of the RV32I 5-stage pipeline, directly upstream of the writeback mux.
- Takes EX/MEM pipeline-register outputs and drives a ready-handshaked data-memory port.
- Handles byte/half/word alignment, byte enables and load sign/zero-extension, plus a memory-latency stall and a timeout.
- Registers the MEM/WB pipeline register, which feeds the writeback stage's ALU-result, memory-data and memToReg inputs.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles an access may wait for dmem_ready (counted from the first request cycle); 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- ex_valid  in  1  EX/MEM holds a valid instruction.
- ex_alu_result  in  32  ALU result / effective address.
- ex_store_data  in  32  rs2 value for stores.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- ex_funct3  in  3  access size/sign.
- ex_rd  in  5  destination register.
- ex_reg_write  in  1  writes rd.
- ex_mem_to_reg  in  1  writeback selects memory data.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word address, {ex_alu_result[31:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ready  in  1  access complete this cycle; may be high in the request cycle.
- dmem_rdata  in  32  read word, valid when dmem_ready.
- mem_stall  out  1  hold PC/IF/ID/EX and EX/MEM stable.
- wb_valid  out  1  MEM/WB valid.
- wb_alu_result  out  32  to writeback ALU-result input.
- wb_mem_data  out  32  formatted load data.
- wb_mem_to_reg  out  1  to writeback memToReg.
- wb_rd  out  5  destination register.
- wb_reg_write  out  1  register-file write enable.
- wb_fault  out  1  instruction faulted.
- wb_fault_cause  out  2  01 misaligned, 10 illegal funct3, 11 timeout.

Behaviour:
- Reset: rst_n low at a rising edge clears all wb_* outputs to 0, sets the FSM to IDLE and the counter to 0. While rst_n is low, dmem_req and mem_stall are forced to 0. Reset mid-access abandons the access with no writeback.
- Access condition: acc = ex_valid & (ex_mem_read | ex_mem_write). If both read and write are set, the access is treated as a store.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Misaligned: half-word with addr[0]=1; word with addr[1:0]!=0.
- Illegal or misaligned access: dmem_req=0, no stall. Next edge, MEM/WB captures wb_valid=1, wb_reg_write=0, wb_fault=1 with the cause. Illegal takes priority over misaligned.
- Legal access: dmem_req = acc combinationally, and dmem_we, dmem_addr, dmem_wdata, dmem_be are combinational from the EX/MEM inputs. mem_stall = dmem_req & ~dmem_ready & ~timeout_hit.
- FSM (state and counter are the only sequential control):
  - IDLE → WAIT when dmem_req & ~dmem_ready & ~timeout_hit; counter becomes 1.
  - WAIT increments the counter each cycle; WAIT → IDLE on dmem_ready or timeout_hit.
  - timeout_hit = (TIMEOUT_CYCLES!=0) & (count == TIMEOUT_CYCLES-1) & ~dmem_ready.
- Timeout: that cycle releases the stall. MEM/WB captures a fault with cause 11, wb_reg_write=0, wb_mem_data=0.
- Stores:
  - SB: wdata {4{d[7:0]}}, be 0001<<addr[1:0].
  - SH: wdata {2{d[15:0]}}, be 0011<<addr[1:0].
  - SW: wdata d, be 1111.
  - Non-store: be=0000.
- Loads: select the byte/half at addr[1:0] from dmem_rdata. Sign-extend for LB/LH, zero-extend for LBU/LHU.
- MEM/WB register, updated every rising edge:
  - Stalled: insert a bubble (wb_valid=0, wb_reg_write=0, wb_fault=0, other fields don't-care but held).
  - Not stalled: capture the EX fields. wb_reg_write = ex_valid & ex_reg_write & ~fault. wb_mem_data = formatted rdata for a completed load, else 0.
  - ex_valid=0: capture a bubble.
- Latency: a zero-wait access completes in 1 cycle (result in MEM/WB the next edge). An N-wait access stalls N cycles.
- Upstream must hold EX/MEM inputs stable while mem_stall=1. Behaviour is undefined otherwise.

Test Plan:
- LW at addr 0x100, dmem_ready same cycle, rdata 0xDEADBEEF → no stall; next edge wb_mem_data=0xDEADBEEF, wb_reg_write=1, wb_mem_to_reg=1.
- LB addr 0x103, rdata 0x80112233 → wb_mem_data=0xFFFFFF80. LBU same → 0x00000080. LHU addr 0x102 → 0x00008011.
- SB addr 0x201, data 0x000000A5 → dmem_be=0010, dmem_wdata=0xA5A5A5A5, dmem_we=1. SH addr 0x202 → be=1100.
- LW with dmem_ready delayed 3 cycles → mem_stall high 3 cycles, 3 bubbles into MEM/WB, then the load result once.
- LH addr 0x101 → dmem_req=0, wb_fault=1, cause 01, wb_reg_write=0. funct3=011 load → cause 10.
- TIMEOUT_CYCLES=4, dmem_ready never asserted → stall for cycles 0–2, released on cycle 3, wb_fault cause 11. rst_n low during WAIT → next edge IDLE, dmem_req=0, wb_* zero.

Source files
------------

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// MEM stage of the RV32I five-stage pipeline.
//
// This stage takes the EX/MEM pipeline register and drives a ready-handshaked
// data-memory port. It performs the following work:
//   - Checks funct3 legality and address alignment for each access.
//   - Builds byte enables and lane-replicated store data.
//   - Formats load data with sign or zero extension.
//   - Stalls upstream while memory is busy, with an optional timeout.
//   - Registers the MEM/WB pipeline register that feeds writeback.
//
// Parameters
//   TIMEOUT_CYCLES  Maximum number of cycles an access may wait for
//                   dmem_ready, counted from the first request cycle.
//                   A value of 0 disables the timeout.
//
// Ports
//   clk, rst_n           Clock (rising edge) and synchronous active-low reset.
//   ex_*                 EX/MEM fields: valid, ALU result/address, store data,
//                        read/write, funct3, rd, reg_write, mem_to_reg.
//   dmem_req/we/addr/
//   wdata/be             Combinational data-memory request.
//   dmem_ready/rdata     Memory completion and read word.
//   mem_stall            Freezes PC/IF/ID/EX and EX/MEM while memory is busy.
//   wb_*                 Registered MEM/WB fields. These are valid, ALU result,
//                        formatted load data, mem_to_reg, rd, reg_write, and
//                        the fault flag with its cause.
// -----------------------------------------------------------------------------
module mem_access_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 32'd16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_store_data,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic [2:0]  ex_funct3,
   input  logic [4:0]  ex_rd,
   input  logic        ex_reg_write,
   input  logic        ex_mem_to_reg,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        mem_stall,
   output logic        wb_valid,
   output logic [31:0] wb_alu_result,
   output logic [31:0] wb_mem_data,
   output logic        wb_mem_to_reg,
   output logic [4:0]  wb_rd,
   output logic        wb_reg_write,
   output logic        wb_fault,
   output logic [1:0]  wb_fault_cause
);

   // funct3 encodings shared by loads and stores
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

   // The counter value that marks the last permitted wait cycle.
   // TO_LAST wraps when the timeout is disabled, so TO_EN guards every use.
   localparam logic        TO_EN   = (TIMEOUT_CYCLES != 32'd0);
   localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 32'd1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t      r_state;
   logic [31:0] r_count;

   logic        w_acc;
   logic        w_is_store;
   logic        w_illegal;
   logic        w_misaligned;
   logic        w_req;
   logic        w_timeout_hit;
   logic        w_stall;
   logic        w_load_done;
   logic        w_fault;
   logic [1:0]  w_cause;

   // ---------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------

   // Returns 1 when funct3 names a supported access of the given direction.
   function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
      logic ok;
      if (is_store) begin
         case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            default:          ok = 1'b0;
         endcase
      end else begin
         case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
            default:                        ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

   // Halfwords need an even address and words need a word-aligned address.
   // funct3[1:0] encodes the access size for both signed and unsigned loads.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      logic mis;
      case (f3[1:0])
         2'b01:   mis = off[0];
         2'b10:   mis = (off != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Replicate store data across every lane it may land in. The memory then
   // only needs the byte enables and never has to shift the data.
   function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] w;
      case (f3)
         F3_B:    w = {4{d[7:0]}};
         F3_H:    w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

   // Byte enables for a store of the given size at the given byte offset.
   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] be;
      case (f3)
         F3_B:    be = 4'b0001 << off;
         F3_H:    be = 4'b0011 << off;
         F3_W:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Extract and extend the addressed byte or halfword of the read word.
   function automatic logic [31:0] load_format(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] rd_word);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'b00:   b = rd_word[7:0];
         2'b01:   b = rd_word[15:8];
         2'b10:   b = rd_word[23:16];
         2'b11:   b = rd_word[31:24];
         default: b = 8'h00;
      endcase
      if (off[1]) begin
         h = rd_word[31:16];
      end else begin
         h = rd_word[15:0];
      end
      case (f3)
         F3_B:    r = {{24{b[7]}}, b};
         F3_H:    r = {{16{h[15]}}, h};
         F3_W:    r = rd_word;
         F3_BU:   r = {24'h000000, b};
         F3_HU:   r = {16'h0000, h};
         default: r = 32'h0000_0000;
      endcase
      return r;
   endfunction

   // ---------------------------------------------------------------------
   // Access decode, request and stall generation
   // ---------------------------------------------------------------------

   // Classify the EX/MEM access and derive request, stall, and fault signals.
   always_comb begin
      w_acc        = ex_valid & (ex_mem_read | ex_mem_write);
      // A simultaneous read+write request is handled as a store.
      w_is_store   = ex_mem_write;
      w_illegal    = w_acc & ~f3_legal(w_is_store, ex_funct3);
      // Illegal has priority, so misalignment is only reported on legal funct3.
      w_misaligned = w_acc & ~w_illegal & is_misaligned(ex_funct3, ex_alu_result[1:0]);
      // Reset masks the request so an abandoned access never reaches memory.
      w_req        = rst_n & w_acc & ~w_illegal & ~w_misaligned;
      // The counter is 0 in the first request cycle and increments while
      // waiting. Cycle TIMEOUT_CYCLES-1 is therefore the last one allowed.
      w_timeout_hit = w_req & TO_EN & (r_count == TO_LAST) & ~dmem_ready;
      w_stall       = w_req & ~dmem_ready & ~w_timeout_hit;
      w_load_done   = w_req & ~w_is_store & dmem_ready;
      w_fault       = w_illegal | w_misaligned | w_timeout_hit;
      if (w_illegal) begin
         w_cause = CAUSE_ILLEGAL;
      end else if (w_misaligned) begin
         w_cause = CAUSE_MISALIGN;
      end else if (w_timeout_hit) begin
         w_cause = CAUSE_TIMEOUT;
      end else begin
         w_cause = CAUSE_NONE;
      end
   end

   assign dmem_req   = w_req;
   assign dmem_we    = w_req & w_is_store;
   assign dmem_addr  = {ex_alu_result[31:2], 2'b00};
   assign dmem_wdata = store_wdata(ex_funct3, ex_store_data);
   assign dmem_be    = (w_req & w_is_store) ? store_be(ex_funct3, ex_alu_result[1:0])
                                            : 4'b0000;
   assign mem_stall  = w_stall;

   // ---------------------------------------------------------------------
   // Wait-state FSM and latency counter
   // ---------------------------------------------------------------------

   // Track memory wait cycles so the timeout can release a hung access.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_count <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_stall) begin
                  r_state <= ST_WAIT;
                  r_count <= 32'd1;
               end else begin
                  r_state <= ST_IDLE;
                  r_count <= 32'd0;
               end
            end
            ST_WAIT: begin
               // Leaving on ~stall covers ready, timeout, or a dropped request.
               if (!w_stall) begin
                  r_state <= ST_IDLE;
                  r_count <= 32'd0;
               end else begin
                  r_state <= ST_WAIT;
                  r_count <= r_count + 32'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_count <= 32'd0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // MEM/WB pipeline register
   // ---------------------------------------------------------------------

   // Capture the retiring instruction, or insert a bubble while stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb_valid       <= 1'b0;
         wb_alu_result  <= 32'h0000_0000;
         wb_mem_data    <= 32'h0000_0000;
         wb_mem_to_reg  <= 1'b0;
         wb_rd          <= 5'd0;
         wb_reg_write   <= 1'b0;
         wb_fault       <= 1'b0;
         wb_fault_cause <= 2'b00;
      end else if (w_stall) begin
         // The data fields hold their values and only the control bits
         // are cleared.
         wb_valid       <= 1'b0;
         wb_reg_write   <= 1'b0;
         wb_fault       <= 1'b0;
      end else begin
         wb_valid       <= ex_valid;
         wb_alu_result  <= ex_alu_result;
         wb_mem_to_reg  <= ex_mem_to_reg;
         wb_rd          <= ex_rd;
         wb_reg_write   <= ex_valid & ex_reg_write & ~w_fault;
         wb_fault       <= w_fault;
         wb_fault_cause <= w_cause;
         wb_mem_data    <= w_load_done ? load_format(ex_funct3, ex_alu_result[1:0], dmem_rdata)
                                       : 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

   logic        clk;
   logic        rst_n;
   logic        ex_valid;
   logic [31:0] ex_alu_result;
   logic [31:0] ex_store_data;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic [2:0]  ex_funct3;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        ex_mem_to_reg;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic        mem_stall;
   logic        wb_valid;
   logic [31:0] wb_alu_result;
   logic [31:0] wb_mem_data;
   logic        wb_mem_to_reg;
   logic [4:0]  wb_rd;
   logic        wb_reg_write;
   logic        wb_fault;
   logic [1:0]  wb_fault_cause;

   int errors = 0;
   int checks = 0;

   mem_access_stage #(.TIMEOUT_CYCLES(32'd4)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
      .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
      .wb_valid(wb_valid), .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
      .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
      .wb_fault(wb_fault), .wb_fault_cause(wb_fault_cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one EX/MEM instruction onto the inputs.
   task automatic set_ex(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] rd, input logic rw, input logic m2r);
      ex_valid      = 1'b1;
      ex_mem_read   = rd_en;
      ex_mem_write  = wr_en;
      ex_funct3     = f3;
      ex_alu_result = addr;
      ex_store_data = sdata;
      ex_rd         = rd;
      ex_reg_write  = rw;
      ex_mem_to_reg = m2r;
   endtask

   task automatic set_idle();
      ex_valid      = 1'b0;
      ex_mem_read   = 1'b0;
      ex_mem_write  = 1'b0;
      ex_funct3     = 3'b000;
      ex_alu_result = 32'h0;
      ex_store_data = 32'h0;
      ex_rd         = 5'd0;
      ex_reg_write  = 1'b0;
      ex_mem_to_reg = 1'b0;
      dmem_ready    = 1'b0;
      dmem_rdata    = 32'h0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_idle();
      @(negedge clk);
      set_ex(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd3, 1'b1, 1'b1);
      #1;
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", dmem_req); end
      checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", mem_stall); end
      @(posedge clk); #1;
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid); end
      checks++; if (wb_reg_write !== 1'b0 || wb_fault !== 1'b0) begin errors++; $display("FAIL rst_wb_ctl: rw=%b fault=%b want 0 0", wb_reg_write, wb_fault); end
      checks++; if (wb_mem_data !== 32'h0 || wb_alu_result !== 32'h0) begin errors++; $display("FAIL rst_wb_data: mem=%h alu=%h want 0 0", wb_mem_data, wb_alu_result); end
      @(negedge clk);
      set_idle();
      rst_n = 1'b1;
   endtask

   task automatic test_lw_zero_wait();
      @(negedge clk);
      set_ex(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 1'b1, 1'b1);
      dmem_ready = 1'b1; dmem_rdata = 32'hDEADBEEF;
      #1;
      checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin errors++; $display("FAIL lw_req: req=%b we=%b want 1 0", dmem_req, dmem_we); end
      checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL lw_stall: got %b want 0", mem_stall); end
      checks++; if (dmem_addr !== 32'h100 || dmem_be !== 4'b0000) begin errors++; $display("FAIL lw_addr_be: addr=%h be=%b want 100 0000", dmem_addr, dmem_be); end
      @(posedge clk); #1;
      checks++; if (wb_mem_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", wb_mem_data); end
      checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b1 || wb_mem_to_reg !== 1'b1) begin errors++; $display("FAIL lw_ctl: v=%b rw=%b m2r=%b want 1 1 1", wb_valid, wb_reg_write, wb_mem_to_reg); end
      checks++; if (wb_rd !== 5'd5 || wb_alu_result !== 32'h100 || wb_fault !== 1'b0) begin errors++; $display("FAIL lw_fields: rd=%0d alu=%h fault=%b want 5 100 0", wb_rd, wb_alu_result, wb_fault); end
   endtask

   task automatic test_load_format();
      logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b001, 3'b000};
      logic [31:0] adr [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h100};
      logic [31:0] exp [6] = '{32'hFFFFFF80, 32'h00000080, 32'h00008011,
                               32'hFFFF8011, 32'h00002233, 32'h00000033};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         set_ex(1'b1, 1'b0, f3[i], adr[i], 32'h0, 5'd7, 1'b1, 1'b1);
         dmem_ready = 1'b1; dmem_rdata = 32'h80112233;
         @(posedge clk); #1;
         checks++;
         if (wb_mem_data !== exp[i] || wb_fault !== 1'b0) begin
            errors++;
            $display("FAIL load_fmt[%0d]: data=%h fault=%b want %h 0", i, wb_mem_data, wb_fault, exp[i]);
         end
      end
   endtask

   task automatic test_stores();
      logic [2:0]  f3  [3] = '{3'b000, 3'b001, 3'b010};
      logic [31:0] adr [3] = '{32'h201, 32'h202, 32'h204};
      logic [31:0] dat [3] = '{32'h000000A5, 32'h1234BEEF, 32'hCAFEF00D};
      logic [31:0] ewd [3] = '{32'hA5A5A5A5, 32'hBEEFBEEF, 32'hCAFEF00D};
      logic [3:0]  ebe [3] = '{4'b0010, 4'b1100, 4'b1111};
      logic [31:0] ead [3] = '{32'h200, 32'h200, 32'h204};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         set_ex(1'b0, 1'b1, f3[i], adr[i], dat[i], 5'd0, 1'b0, 1'b0);
         dmem_ready = 1'b1; dmem_rdata = 32'h55555555;
         #1;
         checks++;
         if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== ebe[i] ||
             dmem_wdata !== ewd[i] || dmem_addr !== ead[i]) begin
            errors++;
            $display("FAIL store[%0d]: req=%b we=%b be=%b wd=%h ad=%h want 1 1 %b %h %h",
                     i, dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr, ebe[i], ewd[i], ead[i]);
         end
         @(posedge clk); #1;
         checks++;
         if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || wb_mem_data !== 32'h0) begin
            errors++;
            $display("FAIL store_wb[%0d]: v=%b rw=%b data=%h want 1 0 0", i, wb_valid, wb_reg_write, wb_mem_data);
         end
      end
   endtask

   task automatic test_wait_states();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         set_ex(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd9, 1'b1, 1'b1);
         dmem_ready = 1'b0; dmem_rdata = 32'h0;
         #1;
         checks++; if (mem_stall !== 1'b1 || dmem_req !== 1'b1) begin errors++; $display("FAIL wait_stall[%0d]: stall=%b req=%b want 1 1", c, mem_stall, dmem_req); end
         @(posedge clk); #1;
         checks++; if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0 || wb_fault !== 1'b0) begin errors++; $display("FAIL wait_bubble[%0d]: v=%b rw=%b f=%b want 0 0 0", c, wb_valid, wb_reg_write, wb_fault); end
      end
      @(negedge clk);
      dmem_ready = 1'b1; dmem_rdata = 32'h0BADF00D;
      #1;
      checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL wait_release: stall=%b want 0", mem_stall); end
      @(posedge clk); #1;
      checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b1 || wb_mem_data !== 32'h0BADF00D || wb_fault !== 1'b0) begin errors++; $display("FAIL wait_result: v=%b rw=%b data=%h f=%b want 1 1 0badf00d 0", wb_valid, wb_reg_write, wb_mem_data, wb_fault); end
      @(negedge clk);
      set_idle();
      @(posedge clk); #1;
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL wait_once: v=%b want 0", wb_valid); end
   endtask

   task automatic test_faults();
      logic        rd_en [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic        wr_en [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [2:0]  f3    [5] = '{3'b001, 3'b011, 3'b010, 3'b100, 3'b011};
      logic [31:0] adr   [5] = '{32'h101, 32'h100, 32'h102, 32'h200, 32'h101};
      logic [1:0]  cause [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         set_ex(rd_en[i], wr_en[i], f3[i], adr[i], 32'h12345678, 5'd4, 1'b1, rd_en[i]);
         dmem_ready = 1'b1; dmem_rdata = 32'hFFFFFFFF;
         #1;
         checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || dmem_be !== 4'b0000) begin errors++; $display("FAIL fault_req[%0d]: req=%b stall=%b be=%b want 0 0 0000", i, dmem_req, mem_stall, dmem_be); end
         @(posedge clk); #1;
         checks++;
         if (wb_valid !== 1'b1 || wb_fault !== 1'b1 || wb_fault_cause !== cause[i] ||
             wb_reg_write !== 1'b0 || wb_mem_data !== 32'h0) begin
            errors++;
            $display("FAIL fault_wb[%0d]: v=%b f=%b cause=%b rw=%b data=%h want 1 1 %b 0 0",
                     i, wb_valid, wb_fault, wb_fault_cause, wb_reg_write, wb_mem_data, cause[i]);
         end
      end
   endtask

   task automatic test_bubble();
      @(negedge clk);
      set_ex(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd6, 1'b1, 1'b1);
      ex_valid = 1'b0;
      dmem_ready = 1'b1; dmem_rdata = 32'h11111111;
      #1;
      checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL bubble_req: req=%b stall=%b want 0 0", dmem_req, mem_stall); end
      @(posedge clk); #1;
      checks++; if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0 || wb_fault !== 1'b0) begin errors++; $display("FAIL bubble_wb: v=%b rw=%b f=%b want 0 0 0", wb_valid, wb_reg_write, wb_fault); end
   endtask

   // Timeout 4: cycles 0-2 stall, cycle 3 releases with cause 11.
   task automatic test_timeout();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         set_ex(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd8, 1'b1, 1'b1);
         dmem_ready = 1'b0; dmem_rdata = 32'hAAAAAAAA;
         #1;
         checks++; if (mem_stall !== (c < 3)) begin errors++; $display("FAIL timeout_stall[%0d]: stall=%b want %b", c, mem_stall, (c < 3)); end
         @(posedge clk); #1;
      end
      checks++;
      if (wb_valid !== 1'b1 || wb_fault !== 1'b1 || wb_fault_cause !== 2'b11 ||
          wb_reg_write !== 1'b0 || wb_mem_data !== 32'h0) begin
         errors++;
         $display("FAIL timeout_wb: v=%b f=%b cause=%b rw=%b data=%h want 1 1 11 0 0",
                  wb_valid, wb_fault, wb_fault_cause, wb_reg_write, wb_mem_data);
      end
      @(negedge clk);
      set_idle();
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_access();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         set_ex(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd2, 1'b1, 1'b1);
         dmem_ready = 1'b0;
         #1;
         checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL rstmid_pre[%0d]: stall=%b want 1", c, mem_stall); end
         @(posedge clk);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL rstmid_force: req=%b stall=%b want 0 0", dmem_req, mem_stall); end
      @(posedge clk); #1;
      checks++; if (wb_valid !== 1'b0 || wb_fault !== 1'b0 || wb_alu_result !== 32'h0 || wb_fault_cause !== 2'b00) begin errors++; $display("FAIL rstmid_wb: v=%b f=%b alu=%h cause=%b want 0 0 0 00", wb_valid, wb_fault, wb_alu_result, wb_fault_cause); end
      // A counter cleared back to 0 gives the full three stall cycles again.
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         rst_n = 1'b1;
         #1;
         checks++; if (mem_stall !== (c < 3)) begin errors++; $display("FAIL rstmid_restart[%0d]: stall=%b want %b", c, mem_stall, (c < 3)); end
         @(posedge clk);
      end
      @(negedge clk);
      set_idle();
   endtask

   initial begin
      set_idle();
      rst_n = 1'b0;
      test_reset();
      test_lw_zero_wait();
      test_load_format();
      test_stores();
      test_wait_states();
      test_faults();
      test_bubble();
      test_timeout();
      test_reset_mid_access();
      @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
